// File: rtl/color_bbox_scanner.sv
// Scans an RGB444 frame buffer in raster order and reports the bounding box and
// count of pixels whose target channel is bright while the other two are dark.
module color_bbox_scanner #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int ADDR_W  = 17,
  parameter int COORD_W = 9,
  parameter int RD_LAT  = 1,
  parameter int CNT_W   = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_flag,
  input  logic               ack_flag,
  input  logic [1:0]         chan_sel,
  input  logic [3:0]         thr_hi,
  input  logic [3:0]         thr_lo,
  input  logic [11:0]        data_pixel,
  output logic [ADDR_W-1:0]  address_to_read,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [CNT_W-1:0]   pix_count,
  output logic               found,
  output logic               busy,
  output logic               done_flag,
  output logic               error_flag
);

  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [COORD_W-1:0] X_LAST     = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST     = COORD_W'(V_RES - 1);
  localparam logic [2:0]         DRAIN_LAST = 3'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  function automatic logic pix_match(input logic [11:0] pix, input logic [1:0] sel,
                                     input logic [3:0] hi, input logic [3:0] lo);
    logic m;
    case (sel)
      2'd0:    m = (pix[11:8] > hi) && (pix[7:4] < lo) && (pix[3:0] < lo);
      2'd1:    m = (pix[7:4] > hi) && (pix[11:8] < lo) && (pix[3:0] < lo);
      2'd2:    m = (pix[3:0] > hi) && (pix[11:8] < lo) && (pix[7:4] < lo);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  state_t               state_r, state_nxt_s;
  logic [1:0]           chan_r;
  logic [3:0]           thr_hi_r, thr_lo_r;
  logic                 issue_vld_r;
  logic [COORD_W-1:0]   x_r, y_r;
  logic [2:0]           drain_cnt_r;
  logic [RD_LAT-1:0]    vld_pipe_r;
  logic [COORD_W-1:0]   x_pipe_r [RD_LAT];
  logic [COORD_W-1:0]   y_pipe_r [RD_LAT];
  logic [COORD_W-1:0]   run_xmin_r, run_xmax_r, run_ymin_r, run_ymax_r;
  logic [COORD_W-1:0]   run_xmin_s, run_xmax_s, run_ymin_s, run_ymax_s;
  logic [CNT_W-1:0]     run_cnt_r, run_cnt_s;
  logic                 run_any_r, run_any_s;
  logic                 start_ok_s, last_issue_s, hit_s;
  logic [COORD_W-1:0]   px_s, py_s;

  assign start_ok_s   = (state_r == IDLE) && start_flag;
  // The last address has been on the bus for a full cycle once this is true.
  assign last_issue_s = issue_vld_r && (address_to_read == ADDR_LAST);
  assign px_s         = x_pipe_r[RD_LAT-1];
  assign py_s         = y_pipe_r[RD_LAT-1];
  assign hit_s        = vld_pipe_r[RD_LAT-1] && pix_match(data_pixel, chan_r, thr_hi_r, thr_lo_r);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_flag) state_nxt_s = (chan_sel == 2'd3) ? ERROR : SCAN;
        else            state_nxt_s = IDLE;
      end
      SCAN: begin
        if (last_issue_s) state_nxt_s = DRAIN;
        else              state_nxt_s = SCAN;
      end
      DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) state_nxt_s = DONE;
        else                           state_nxt_s = DRAIN;
      end
      DONE: begin
        if (ack_flag) state_nxt_s = IDLE;
        else          state_nxt_s = DONE;
      end
      ERROR: begin
        if (ack_flag) state_nxt_s = IDLE;
        else          state_nxt_s = ERROR;
      end
      default: state_nxt_s = ERROR;
    endcase
  end

  // Configuration latch, raster address generator and drain timer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chan_r          <= 2'd0;
      thr_hi_r        <= 4'd0;
      thr_lo_r        <= 4'd0;
      address_to_read <= {ADDR_W{1'b0}};
      issue_vld_r     <= 1'b0;
      x_r             <= {COORD_W{1'b0}};
      y_r             <= {COORD_W{1'b0}};
      drain_cnt_r     <= 3'd0;
    end else begin
      if (start_ok_s) begin
        chan_r   <= chan_sel;
        thr_hi_r <= thr_hi;
        thr_lo_r <= thr_lo;
      end
      // First SCAN cycle issues address 0; the address then holds after N-1.
      if (state_r == SCAN) begin
        if (!issue_vld_r) begin
          address_to_read <= {ADDR_W{1'b0}};
          x_r             <= {COORD_W{1'b0}};
          y_r             <= {COORD_W{1'b0}};
          issue_vld_r     <= 1'b1;
        end else if (last_issue_s) begin
          issue_vld_r <= 1'b0;
        end else begin
          address_to_read <= address_to_read + ADDR_W'(1);
          if (x_r == X_LAST) begin
            x_r <= {COORD_W{1'b0}};
            y_r <= y_r + COORD_W'(1);
          end else begin
            x_r <= x_r + COORD_W'(1);
          end
        end
      end
      if (state_r == DRAIN) drain_cnt_r <= drain_cnt_r + 3'd1;
      else                  drain_cnt_r <= 3'd0;
    end
  end

  // Coordinate pipeline that lines x/y up with the returning pixel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe_r <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        x_pipe_r[i] <= {COORD_W{1'b0}};
        y_pipe_r[i] <= {COORD_W{1'b0}};
      end
    end else begin
      vld_pipe_r[0] <= issue_vld_r;
      x_pipe_r[0]   <= x_r;
      y_pipe_r[0]   <= y_r;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_r[i] <= vld_pipe_r[i-1];
        x_pipe_r[i]   <= x_pipe_r[i-1];
        y_pipe_r[i]   <= y_pipe_r[i-1];
      end
    end
  end

  // Running bounding box and count, including the pixel arriving this cycle.
  always_comb begin
    run_xmin_s = run_xmin_r;
    run_xmax_s = run_xmax_r;
    run_ymin_s = run_ymin_r;
    run_ymax_s = run_ymax_r;
    run_cnt_s  = run_cnt_r;
    run_any_s  = run_any_r;
    if (hit_s) begin
      run_xmin_s = (px_s <= run_xmin_r) ? px_s : run_xmin_r;
      run_xmax_s = (px_s >= run_xmax_r) ? px_s : run_xmax_r;
      run_ymin_s = (py_s <= run_ymin_r) ? py_s : run_ymin_r;
      run_ymax_s = (py_s >= run_ymax_r) ? py_s : run_ymax_r;
      run_cnt_s  = (run_cnt_r == CNT_MAX) ? run_cnt_r : run_cnt_r + CNT_W'(1);
      run_any_s  = 1'b1;
    end else begin
      run_any_s  = run_any_r;
    end
  end

  // Running result registers, re-initialised on every accepted start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_xmin_r <= {COORD_W{1'b0}};
      run_xmax_r <= {COORD_W{1'b0}};
      run_ymin_r <= {COORD_W{1'b0}};
      run_ymax_r <= {COORD_W{1'b0}};
      run_cnt_r  <= {CNT_W{1'b0}};
      run_any_r  <= 1'b0;
    end else if (start_ok_s) begin
      run_xmin_r <= X_LAST;
      run_xmax_r <= {COORD_W{1'b0}};
      run_ymin_r <= Y_LAST;
      run_ymax_r <= {COORD_W{1'b0}};
      run_cnt_r  <= {CNT_W{1'b0}};
      run_any_r  <= 1'b0;
    end else begin
      run_xmin_r <= run_xmin_s;
      run_xmax_r <= run_xmax_s;
      run_ymin_r <= run_ymin_s;
      run_ymax_r <= run_ymax_s;
      run_cnt_r  <= run_cnt_s;
      run_any_r  <= run_any_s;
    end
  end

  // Status flags and published results; results load only on entry to DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_min      <= {COORD_W{1'b0}};
      x_max      <= {COORD_W{1'b0}};
      y_min      <= {COORD_W{1'b0}};
      y_max      <= {COORD_W{1'b0}};
      pix_count  <= {CNT_W{1'b0}};
      found      <= 1'b0;
      busy       <= 1'b0;
      done_flag  <= 1'b0;
      error_flag <= 1'b0;
    end else begin
      busy       <= (state_nxt_s == SCAN) || (state_nxt_s == DRAIN);
      done_flag  <= (state_nxt_s == DONE);
      error_flag <= (state_nxt_s == ERROR);
      if ((state_r == DRAIN) && (state_nxt_s == DONE)) begin
        found     <= run_any_s;
        x_min     <= run_any_s ? run_xmin_s : {COORD_W{1'b0}};
        x_max     <= run_any_s ? run_xmax_s : {COORD_W{1'b0}};
        y_min     <= run_any_s ? run_ymin_s : {COORD_W{1'b0}};
        y_max     <= run_any_s ? run_ymax_s : {COORD_W{1'b0}};
        pix_count <= run_any_s ? run_cnt_s  : {CNT_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_color_bbox_scanner.sv
// Scoreboard bench for color_bbox_scanner on an 8x4 frame with one-cycle read latency.
module tb_color_bbox_scanner;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        reset, start_flag, ack_flag;
  logic [1:0]  chan_sel;
  logic [3:0]  thr_hi, thr_lo;
  logic [11:0] data_pixel = 12'h000;
  logic [16:0] address_to_read;
  logic [8:0]  x_min, x_max, y_min, y_max;
  logic [16:0] pix_count;
  logic        found, busy, done_flag, error_flag;

  always #5 clk = ~clk;

  color_bbox_scanner #(
    .H_RES(8), .V_RES(4), .ADDR_W(17), .COORD_W(9), .RD_LAT(1), .CNT_W(17)
  ) dut (
    .clk(clk), .reset(reset), .start_flag(start_flag), .ack_flag(ack_flag),
    .chan_sel(chan_sel), .thr_hi(thr_hi), .thr_lo(thr_lo), .data_pixel(data_pixel),
    .address_to_read(address_to_read), .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max), .pix_count(pix_count), .found(found),
    .busy(busy), .done_flag(done_flag), .error_flag(error_flag)
  );

  // Frame buffer model with one cycle of read latency.
  logic [11:0] mem [N];
  always @(posedge clk) data_pixel <= mem[address_to_read[4:0]];

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit is_err;
    bit fnd;
    int xmn, xmx, ymn, ymx, cnt;
    int lat;
    int at_edge;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(bit err, bit f, int a, int b, int c, int d, int cnt, int lat);
    exp_t e;
    e.is_err = err; e.fnd = f;
    e.xmn = a; e.xmx = b; e.ymn = c; e.ymx = d; e.cnt = cnt;
    e.lat = lat; e.at_edge = 0;
    return e;
  endfunction

  // Monitor: pops an expectation whenever done_flag or error_flag rises.
  bit done_q = 1'b0;
  bit err_q  = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if ((done_flag && !done_q) || (error_flag && !err_q)) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: done=%0b err=%0b, none expected", done_flag, error_flag);
      end else begin
        e = sb_q.pop_front();
        chk("result_kind", {31'd0, error_flag}, {31'd0, e.is_err});
        chk("result_edge", edge_cnt, e.at_edge);
        chk("busy_at_result", {31'd0, busy}, 32'd0);
        if (!e.is_err) begin
          chk("found", {31'd0, found}, {31'd0, e.fnd});
          chk("x_min", {23'd0, x_min}, e.xmn);
          chk("x_max", {23'd0, x_max}, e.xmx);
          chk("y_min", {23'd0, y_min}, e.ymn);
          chk("y_max", {23'd0, y_max}, e.ymx);
          chk("pix_count", {15'd0, pix_count}, e.cnt);
        end else begin
          chk("done_in_error", {31'd0, done_flag}, 32'd0);
        end
      end
    end
    done_q = done_flag;
    err_q  = error_flag;
  end

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = 12'h000;
  endtask

  task automatic do_start(input logic [1:0] ch, input bit push, input exp_t e);
    @(negedge clk);
    chan_sel = ch; thr_hi = 4'd12; thr_lo = 4'd8; start_flag = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.at_edge = edge_cnt + e.lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    // Scramble configuration to show the latched copy is used.
    start_flag = 1'b0; chan_sel = 2'd3; thr_hi = 4'd0; thr_lo = 4'd15;
  endtask

  task automatic wait_result();
    int k = 0;
    while (!(done_flag || error_flag) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("result_timeout", {31'd0, done_flag | error_flag}, 32'd1);
  endtask

  task automatic do_ack();
    ack_flag = 1'b1;
    @(negedge clk);
    ack_flag = 1'b0;
    chk("ack_done_clr", {31'd0, done_flag}, 32'd0);
    chk("ack_err_clr", {31'd0, error_flag}, 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_addr"}, {15'd0, address_to_read}, 32'd0);
    chk({tag, "_coords"}, {x_min, x_max, y_min[4:0], y_max[4:0]}, 32'd0);
    chk({tag, "_cnt"}, {15'd0, pix_count}, 32'd0);
    chk({tag, "_flags"}, {28'd0, found, busy, done_flag, error_flag}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    reset = 1'b0; start_flag = 1'b0; ack_flag = 1'b0;
    chan_sel = 2'd1; thr_hi = 4'd12; thr_lo = 4'd8;
    clear_mem();
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b1;

    // All-black frame, green target.
    do_start(2'd1, 1'b1, mk(1'b0, 1'b0, 0, 0, 0, 0, 0, 34));
    chk("busy_in_scan", {31'd0, busy}, 32'd1);
    wait_result();
    do_ack();

    // Single green pixel at (5,2).
    clear_mem(); mem[21] = 12'h0F0;
    do_start(2'd1, 1'b1, mk(1'b0, 1'b1, 5, 5, 2, 2, 1, 34));
    wait_result();
    do_ack();

    // Red corners, red then blue target.
    clear_mem(); mem[0] = 12'hF00; mem[31] = 12'hF00;
    do_start(2'd0, 1'b1, mk(1'b0, 1'b1, 0, 7, 0, 3, 2, 34));
    wait_result();
    do_ack();
    do_start(2'd2, 1'b1, mk(1'b0, 1'b0, 0, 0, 0, 0, 0, 34));
    wait_result();
    do_ack();

    // Threshold edges on blue: 0x08D (G=8) and 0x00C (B=12) must not match.
    clear_mem(); mem[9] = 12'h77D; mem[6] = 12'h08D; mem[27] = 12'h00C; mem[20] = 12'h00F;
    do_start(2'd2, 1'b1, mk(1'b0, 1'b1, 1, 4, 1, 2, 2, 34));
    wait_result();
    do_ack();

    // Illegal channel.
    do_start(2'd3, 1'b1, mk(1'b1, 1'b0, 0, 0, 0, 0, 0, 0));
    chk("err_busy", {31'd0, busy}, 32'd0);
    chk("err_done", {31'd0, done_flag}, 32'd0);
    wait_result();
    do_ack();

    // Reset in the middle of a scan, then a normal scan.
    clear_mem(); mem[21] = 12'h0F0;
    do_start(2'd1, 1'b0, mk(1'b0, 1'b0, 0, 0, 0, 0, 0, 0));
    k = 0;
    while (address_to_read != 17'd10 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("addr10_reached", {15'd0, address_to_read}, 32'd10);
    chk("busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state("midscan_reset");
    reset = 1'b1;
    do_start(2'd1, 1'b1, mk(1'b0, 1'b1, 5, 5, 2, 2, 1, 34));
    wait_result();
    do_ack();

    // start together with ack in DONE must not begin a scan.
    clear_mem(); mem[0] = 12'hF00; mem[31] = 12'hF00;
    do_start(2'd0, 1'b1, mk(1'b0, 1'b1, 0, 7, 0, 3, 2, 34));
    wait_result();
    chan_sel = 2'd0; start_flag = 1'b1; ack_flag = 1'b1;
    @(negedge clk);
    start_flag = 1'b0; ack_flag = 1'b0;
    chk("startack_done", {31'd0, done_flag}, 32'd0);
    chk("startack_busy", {31'd0, busy}, 32'd0);
    chk("startack_addr", {15'd0, address_to_read}, 32'd31);
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_addr_hold", {15'd0, address_to_read}, 32'd31);
    chk("idle_result_hold", {23'd0, x_max}, 32'd7);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/color_bbox_scanner.md
COLOR_BBOX_SCANNER -- requirements
Module: color_bbox_scanner

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_RES, 320, pixels per line.
- V_RES, 240, lines per frame.
- ADDR_W, 17, read-address width.
- COORD_W, 9, coordinate width.
- RD_LAT, 1, frame-buffer read latency in cycles, legal range 1..4.
- CNT_W, 17, match-counter width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic on rising edge.
- reset, in, 1, synchronous active-low reset.
- start_flag, in, 1, begin one frame scan.
- ack_flag, in, 1, consumer has taken result or error.
- chan_sel, in, 2, target channel: 0=R, 1=G, 2=B, 3=illegal.
- thr_hi, in, 4, target channel must be strictly greater than this.
- thr_lo, in, 4, both non-target channels must be strictly less than this.
- data_pixel, in, 12, RGB444 pixel; R[11:8], G[7:4], B[3:0].
- address_to_read, out, ADDR_W, raster address y*H_RES+x.
- x_min, x_max, y_min, y_max, out, COORD_W each, bounding box of matching pixels.
- pix_count, out, CNT_W, number of matching pixels.
- found, out, 1, at least one pixel matched.
- busy, out, 1, scan or drain in progress.
- done_flag, out, 1, result valid, awaiting ack.
- error_flag, out, 1, illegal configuration, awaiting ack.

Function
REQ-003 FSM states SHALL be IDLE, SCAN, DRAIN, DONE, ERROR; the encoding SHALL be registered and any unused code SHALL go to ERROR.
REQ-004 In IDLE, start_flag=1 SHALL latch chan_sel, thr_hi and thr_lo, then enter SCAN, or enter ERROR if chan_sel=3.
- start_flag SHALL be ignored in all other states.
REQ-005 In SCAN, address_to_read SHALL step by 1 per cycle from 0 through N-1, where N=H_RES*V_RES.
- The x counter SHALL wrap at H_RES-1; y SHALL increment on that wrap.
- After address N-1 is issued, the FSM SHALL enter DRAIN.
REQ-006 data_pixel SHALL correspond to the address issued RD_LAT cycles earlier.
- x and y SHALL be delayed through an RD_LAT-deep pipeline alongside a valid bit.
REQ-007 DRAIN SHALL last exactly RD_LAT cycles, then enter DONE.
REQ-008 A valid pixel SHALL match iff target channel > thr_hi AND both other channels < thr_lo, using the latched configuration.
REQ-009 On a match, the running min/max registers SHALL update with inclusive compares.
- Running min SHALL initialise to H_RES-1 / V_RES-1 and running max to 0 at scan start.
- pix_count SHALL increment and saturate at 2^CNT_W-1.
REQ-010 On entering DONE, the published outputs SHALL load the running results.
- If no match occurred, found=0 and x_min, x_max, y_min, y_max and pix_count SHALL all be 0.
- Published outputs SHALL otherwise hold their previous values in every other state.
REQ-011 done_flag SHALL be 1 only in DONE.
- It SHALL rise on the (N+RD_LAT+1)th rising edge after the edge sampling start_flag.
REQ-012 DONE and ERROR SHALL hold until ack_flag=1, then return to IDLE on the next edge.
- start_flag asserted together with ack_flag SHALL NOT begin a scan.
REQ-013 busy SHALL be 1 exactly in SCAN and DRAIN; error_flag SHALL be 1 only in ERROR.
REQ-014 address_to_read SHALL hold its last value outside SCAN.

Reset
REQ-015 reset=0 at a rising edge SHALL, in any state including mid-scan, force:
- IDLE.
- address_to_read=0.
- All coordinates and pix_count=0.
- found, busy, done_flag and error_flag=0.
- The pipeline valid bits cleared.
REQ-016 The first start_flag after reset release SHALL behave identically to a start from power-up.

Verification (H_RES=8, V_RES=4, RD_LAT=1, thr_hi=12, thr_lo=8)
REQ-017 All-black frame, chan_sel=1 -> found=0, all coords 0, pix_count=0, done_flag rises 34 edges after start.
REQ-018 Single 0x0F0 pixel at (5,2), chan_sel=1 -> x_min=x_max=5, y_min=y_max=2, pix_count=1, found=1.
REQ-019 0xF00 pixels at (0,0) and (7,3), chan_sel=0 -> box 0..7 by 0..3, pix_count=2; the same frame with chan_sel=2 -> found=0.
REQ-020 Start with chan_sel=3 -> error_flag=1, busy=0, done_flag=0; ack_flag -> IDLE next edge.
REQ-021 reset=0 at scan address 10 -> all outputs at reset values next edge; a following start completes a normal scan.
REQ-022 start_flag and ack_flag both 1 in DONE -> IDLE, done_flag=0, busy stays 0, address_to_read unchanged.
